// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer:
// FSM state encoding and the bit-counter width helper.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Smallest counter width able to index WIDTH bit positions (at least 1).
  function automatic int cnt_width(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) w++;
    return w;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a one-word holding buffer so that
// consecutive words stream out back-to-back with framing strobes.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   buf_reg, buf_next;
  logic               full_reg, full_next;

  logic [WIDTH-1:0]   shift_adv;
  logic               end_bit;
  logic               accept;
  logic               last_bit;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign shift_adv = shift_reg >> 1;
      assign end_bit   = shift_reg[0];
    end else begin : g_msb
      assign shift_adv = shift_reg << 1;
      assign end_bit   = shift_reg[WIDTH-1];
    end
  endgenerate

  assign in_ready    = ~full_reg & ~rst;
  assign accept      = in_valid & in_ready;
  assign last_bit    = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);

  assign out_valid   = (state_reg == SHIFT);
  assign out_bit     = (state_reg == SHIFT) ? end_bit : 1'b0;
  assign frame_start = (state_reg == SHIFT) && (cnt_reg == '0);
  assign frame_end   = last_bit;
  assign busy        = (state_reg == SHIFT) | full_reg;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    buf_next   = buf_reg;
    full_next  = full_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next = in_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Refill from the buffer first; a fresh word is only accepted
          // here when the buffer is empty (in_ready is low while full).
          if (full_reg) begin
            shift_next = buf_reg;
            cnt_next   = '0;
            full_next  = 1'b0;
          end else if (accept) begin
            shift_next = in_data;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          shift_next = shift_adv;
          cnt_next   = cnt_reg + 1'b1;
          if (accept) begin
            buf_next  = in_data;
            full_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      buf_reg   <= '0;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      buf_reg   <= buf_next;
      full_reg  <= full_next;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a 4-bit LSB-first instance feeding a
// modelled right-shift register, plus an 8-bit MSB-first instance.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid, in_ready, out_bit, out_valid, frame_start, frame_end, busy;
  logic [7:0] m_in_data;
  logic       m_in_valid, m_in_ready, m_out_bit, m_out_valid;
  logic       m_frame_start, m_frame_end, m_busy;
  logic [3:0] ds_q;

  int n_checks;
  int n_fail;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_data(m_in_data), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .out_bit(m_out_bit), .out_valid(m_out_valid),
    .frame_start(m_frame_start), .frame_end(m_frame_end), .busy(m_busy)
  );

  // Downstream right_shift_register: serial bit enters at the MSB.
  always @(posedge clk) begin
    if (rst) ds_q <= 4'b0;
    else if (out_valid) ds_q <= {out_bit, ds_q[3:1]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Walks n frame-bit cycles; stream bit i is the expected out_bit on cycle i.
  task automatic check_stream(input string name, input logic [15:0] stream, input int n);
    logic [3:0] got, exp;
    for (int i = 0; i < n; i++) begin
      got = {out_valid, out_bit, frame_start, frame_end};
      exp = {1'b1, stream[i], (i % 4) == 0, (i % 4) == 3};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s[%0d]: got vld/bit/fs/fe=%b expected %b", name, i, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string name, input logic [3:0] exp_q);
    n_checks++;
    if ({out_valid, out_bit, frame_start, frame_end, busy, in_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL %s_idle: got vld/bit/fs/fe/busy/rdy=%b expected 000001", name,
               {out_valid, out_bit, frame_start, frame_end, busy, in_ready});
    end
    n_checks++;
    if (ds_q !== exp_q) begin
      n_fail++;
      $display("FAIL %s_q: got %h expected %h", name, ds_q, exp_q);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0;
    m_in_valid = 1'b0; m_in_data = '0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({in_ready, m_in_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_ready: got %b expected 00", {in_ready, m_in_ready});
      end
    end
    rst = 1'b0;
    #1;
    check_idle("reset", 4'h0);
    n_checks++;
    if ({m_in_ready, m_out_valid, m_out_bit, m_busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_msb: got rdy/vld/bit/busy=%b expected 1000",
               {m_in_ready, m_out_valid, m_out_bit, m_busy});
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1011;
    @(negedge clk);
    in_valid = 1'b0;
    check_stream("single", 16'h000B, 4);
    check_idle("single", 4'b1011);
    $display("test_single: sent 4'hb");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'hA;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready0: got %b expected 1", in_ready);
    end
    in_data = 4'h5;
    fork
      check_stream("b2b", 16'h005A, 8);
      begin
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_ready1: got %b expected 0", in_ready);
        end
        in_valid = 1'b0;
      end
    join
    check_idle("b2b", 4'h5);
    $display("test_back_to_back: sent 4'ha, 4'h5");
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'h3;
    @(negedge clk);
    in_valid = 1'b0;
    fork
      check_stream("simul", 16'h00C3, 8);
      begin
        repeat (3) @(negedge clk);
        n_checks++;
        if ({frame_end, in_ready} !== 2'b11) begin
          n_fail++; $display("FAIL simul_offer: got fe/rdy=%b expected 11", {frame_end, in_ready});
        end
        in_valid = 1'b1; in_data = 4'hC;
        @(negedge clk);
        in_valid = 1'b0;
      end
    join
    check_idle("simul", 4'hC);
    $display("test_simultaneous: sent 4'h3, 4'hc");
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_rdy;
    exp_rdy = 12'b1111_0001_0001;
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'h6;
    @(negedge clk);
    fork
      check_stream("bp", 16'h0E96, 12);
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (in_ready !== exp_rdy[i]) begin
          n_fail++; $display("FAIL bp_ready[%0d]: got %b expected %b", i, in_ready, exp_rdy[i]);
        end
        if (i == 0) in_data = 4'h9;
        if (i == 1) in_data = 4'hE;
        if (i == 5) in_valid = 1'b0;
        @(negedge clk);
      end
    join
    check_idle("bp", 4'hE);
    $display("test_backpressure: sent 4'h6, 4'h9, 4'he");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'hF;
    @(negedge clk);
    in_data = 4'hA;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_bit, busy, in_ready} !== 4'b1110) begin
      n_fail++; $display("FAIL midrst_pre: got vld/bit/busy/rdy=%b expected 1110",
                         {out_valid, out_bit, busy, in_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("midrst", 4'h0);
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, busy} !== 2'b00) begin
        n_fail++; $display("FAIL midrst_lost: got vld/busy=%b expected 00", {out_valid, busy});
      end
    end
    $display("test_reset_mid_frame: 4'hf and 4'ha discarded");
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_bits;
    logic [3:0] got, exp;
    exp_bits = 8'b1000_0001;
    @(negedge clk);
    m_in_valid = 1'b1; m_in_data = 8'h81;
    @(negedge clk);
    m_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {m_out_valid, m_out_bit, m_frame_start, m_frame_end};
      exp = {1'b1, exp_bits[7 - i], i == 0, i == 7};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL msb[%0d]: got vld/bit/fs/fe=%b expected %b", i, got, exp);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({m_out_valid, m_busy, m_in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL msb_idle: got vld/busy/rdy=%b expected 001",
                         {m_out_valid, m_busy, m_in_ready});
    end
    $display("test_msb_first: sent 8'h81");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_frame();
    test_msb_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter LSB_FIRST, default 1; 1 sends bit 0 first, 0 sends bit WIDTH-1 first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port out_bit, output, 1 bit: serial data; drives in_bit of the downstream right_shift_register.
REQ-009 SHALL have port out_valid, output, 1 bit: out_bit carries a frame bit this cycle.
REQ-010 SHALL have port frame_start, output, 1 bit: out_bit is the first bit of a word.
REQ-011 SHALL have port frame_end, output, 1 bit: out_bit is the last bit of a word.
REQ-012 SHALL have port busy, output, 1 bit: shifter holds an unsent or in-flight word.

Function
REQ-013 SHALL transfer a word on a rising edge where in_valid=1 and in_ready=1; no transfer otherwise.
REQ-014 SHALL hold a WIDTH-bit shift register, a bit counter of ceil(log2(WIDTH)) bits, and a one-word holding buffer with a full flag.
REQ-015 SHALL implement a two-state FSM: IDLE (shifter empty) and SHIFT (shifter sending).
REQ-016 IDLE: an accepted word SHALL load directly into the shifter, clear the counter, and enter SHIFT; the holding buffer stays empty.
REQ-017 SHIFT: an accepted word SHALL load into the holding buffer and set its full flag.
REQ-018 in_ready SHALL equal NOT(buffer full), combinationally; it SHALL be 1 in IDLE.
REQ-019 In SHIFT, out_valid SHALL be 1 and out_bit SHALL equal the current shifter end bit (bit 0 if LSB_FIRST=1, else bit WIDTH-1).
REQ-020 In IDLE, out_valid, frame_start and frame_end SHALL be 0, and out_bit SHALL be 0.
REQ-021 Latency: the first bit of a word accepted at edge N SHALL appear on out_bit in the cycle after edge N when the block is IDLE.
REQ-022 frame_start SHALL be 1 when the counter is 0 in SHIFT; frame_end SHALL be 1 when the counter is WIDTH-1 in SHIFT.
REQ-023 Each SHIFT cycle that is not the last bit SHALL shift the register one position toward the end bit and increment the counter.
REQ-024 On the last-bit cycle with the buffer full, the block SHALL load the buffer into the shifter, clear the counter and the full flag, and stay in SHIFT, so frames are back-to-back with no gap.
REQ-025 On the last-bit cycle with the buffer empty and no accepted word, the block SHALL return to IDLE.
REQ-026 On the last-bit cycle with the buffer empty and a word accepted that same edge, the word SHALL load directly into the shifter, and the block SHALL stay in SHIFT with no gap.
REQ-027 busy SHALL equal (state==SHIFT) OR buffer full.
REQ-028 With LSB_FIRST=1 and WIDTH=4, the downstream right_shift_register SHALL hold the accepted word on q[3:0] on the edge after the frame_end cycle.

Reset
REQ-029 While rst=1, in_ready SHALL be 0; at the next edge the state SHALL go to IDLE and the shifter, counter, buffer and full flag SHALL clear.
REQ-030 Reset mid-frame SHALL discard both the in-flight word and the buffered word, with no partial-frame completion.
REQ-031 After reset, all outputs SHALL be 0 except in_ready, which SHALL be 1 from the first cycle with rst=0.

Structure
REQ-032 The FSM state encoding (IDLE, SHIFT) SHALL be defined in the shared package piso_pkg.
REQ-033 The counter-width function SHALL be defined in the shared package piso_pkg.
REQ-034 The block SHALL be one flat module with no sub-modules; the downstream right_shift_register SHALL be instantiated only in the bench.

Verification
REQ-035 Single word: reset, send 4'b1011 once (LSB_FIRST=1) -> out_bit 1,1,0,1 on 4 consecutive cycles, frame_start on cycle 1, frame_end on cycle 4, then IDLE; downstream q=4'b1011.
REQ-036 Back-to-back: send 4'hA then 4'h5 with in_valid held -> 8 contiguous out_valid cycles, in_ready drops after the second accept, and no gap between frames.
REQ-037 Simultaneous: offer a word exactly on the frame_end cycle with the buffer empty -> accepted, and the next frame starts on the next cycle.
REQ-038 Backpressure: with the buffer full, hold in_valid with a third word -> in_ready=0 until the buffer drains, and the third word is sent intact.
REQ-039 Reset mid-frame: assert rst after 2 bits of 4'hF -> outputs 0 next cycle, and the buffered word is lost.
REQ-040 MSB-first: LSB_FIRST=0, WIDTH=8, send 8'h81 -> out_bit 1,0,0,0,0,0,0,1.
